// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm: multi-cycle control sequencer for the 32-bit MIPS datapath.
// Latches the fetched instruction into ir, decodes it into datapath controls,
// and sequences FETCH -> EXEC (-> MEM) so that each instruction retires once.
// Loads and stores run a request/ack handshake with a timeout watchdog.
module mips_ctrl_fsm #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  input  logic        dmem_ack,
  output logic [31:0] ir,
  output logic        reg_dst,
  output logic        jump,
  output logic        jr,
  output logic        branch,
  output logic        bne,
  output logic        mem2reg,
  output logic        alu_src,
  output logic        and_data2alu,
  output logic        shift_ren,
  output logic        shift_len,
  output logic        shift_data2reg,
  output logic [3:0]  alu_ctrl,
  output logic        reg_wrt,
  output logic        pc_en,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic        illegal_op,
  output logic        bus_err,
  output logic [31:0] retired
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2
  } state_t;

  state_t            r_state;
  logic [31:0]       r_ir;
  logic [WAIT_W-1:0] r_wait;
  logic [31:0]       r_retired;

  logic w_legal;
  logic w_is_lw;
  logic w_is_sw;
  logic w_wb;

  assign ir      = r_ir;
  assign retired = r_retired;

  // Combinational decode of the latched instruction into datapath controls
  always_comb begin
    reg_dst        = 1'b0;
    jump           = 1'b0;
    jr             = 1'b0;
    branch         = 1'b0;
    bne            = 1'b0;
    mem2reg        = 1'b0;
    alu_src        = 1'b0;
    and_data2alu   = 1'b0;
    shift_ren      = 1'b0;
    shift_len      = 1'b0;
    shift_data2reg = 1'b0;
    alu_ctrl       = 4'b0000;
    w_legal        = 1'b1;
    w_is_lw        = 1'b0;
    w_is_sw        = 1'b0;
    w_wb           = 1'b1;
    case (r_ir[31:26])
      6'h00: begin
        case (r_ir[5:0])
          6'h20: begin reg_dst = 1'b1; alu_ctrl = 4'b0010; end
          6'h22: begin reg_dst = 1'b1; alu_ctrl = 4'b0110; end
          6'h24: begin reg_dst = 1'b1; alu_ctrl = 4'b0000; end
          6'h25: begin reg_dst = 1'b1; alu_ctrl = 4'b0001; end
          6'h2A: begin reg_dst = 1'b1; alu_ctrl = 4'b0111; end
          6'h00: begin reg_dst = 1'b1; shift_len = 1'b1; shift_data2reg = 1'b1; end
          6'h02: begin reg_dst = 1'b1; shift_ren = 1'b1; shift_data2reg = 1'b1; end
          6'h08: begin jr = 1'b1; w_wb = 1'b0; end
          default: begin w_legal = 1'b0; w_wb = 1'b0; end
        endcase
      end
      6'h08: begin alu_src = 1'b1; alu_ctrl = 4'b0010; end
      6'h0C: begin and_data2alu = 1'b1; alu_ctrl = 4'b0000; end
      6'h23: begin alu_src = 1'b1; mem2reg = 1'b1; alu_ctrl = 4'b0010; w_is_lw = 1'b1; end
      6'h2B: begin alu_src = 1'b1; alu_ctrl = 4'b0010; w_is_sw = 1'b1; w_wb = 1'b0; end
      6'h04: begin branch = 1'b1; alu_ctrl = 4'b0110; w_wb = 1'b0; end
      6'h05: begin bne = 1'b1; alu_ctrl = 4'b0110; w_wb = 1'b0; end
      6'h02: begin jump = 1'b1; w_wb = 1'b0; end
      default: begin w_legal = 1'b0; w_wb = 1'b0; end
    endcase
  end

  // Strobes from current state; the ack cycle completes in place, reset masks everything
  always_comb begin
    reg_wrt    = 1'b0;
    pc_en      = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    case (r_state)
      S_EXEC: begin
        if (!w_legal) begin
          pc_en      = 1'b1;
          illegal_op = 1'b1;
        end else if (!(w_is_lw || w_is_sw)) begin
          pc_en   = 1'b1;
          reg_wrt = w_wb;
        end
      end
      S_MEM: begin
        dmem_rd = w_is_lw;
        dmem_wr = w_is_sw;
        if (dmem_ack) begin
          pc_en   = 1'b1;
          reg_wrt = w_is_lw;
        end else if (r_wait == WAIT_LAST) begin
          pc_en   = 1'b1;
          bus_err = 1'b1;
        end
      end
      default: ;
    endcase
    if (reset) begin
      reg_wrt    = 1'b0;
      pc_en      = 1'b0;
      dmem_rd    = 1'b0;
      dmem_wr    = 1'b0;
      illegal_op = 1'b0;
      bus_err    = 1'b0;
    end
  end

  // Sequencer state, instruction register, wait counter and retire count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_ir      <= 32'd0;
      r_wait    <= '0;
      r_retired <= 32'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (inst_valid) begin
            r_ir    <= inst;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_lw || w_is_sw) begin
            r_wait  <= '0;
            r_state <= S_MEM;
          end else begin
            if (w_legal) r_retired <= r_retired + 32'd1;
            r_state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_retired <= r_retired + 32'd1;
            r_state   <= S_FETCH;
          end else if (r_wait == WAIT_LAST) begin
            r_state <= S_FETCH;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/mips_ctrl_fsm.md
# mips_ctrl_fsm

Multi-cycle control sequencer for the 32-bit MIPS datapath. It latches each fetched instruction into an internal instruction register and decodes it into the datapath's mux/ALU/shifter control lines. It gates register-file writes and PC advance so that each instruction retires exactly once, and it runs a request/acknowledge handshake with data memory for `lw`/`sw`, with a timeout watchdog. It sits between instruction memory, data memory and the datapath; the datapath's `inst` input is driven from `ir`, and its PC register loads only when `pc_en` is high.

## Interface
- `TIMEOUT`, default 16: maximum number of MEM-state cycles to wait for `dmem_ack` before aborting (≥2).
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `inst` in 32: instruction-memory read data.
- `inst_valid` in 1: `inst` is valid this cycle.
- `dmem_ack` in 1: data memory has completed the current access (read data valid on `mem_data` for loads).
- `ir` out 32: latched instruction; drives the datapath's `inst`.
- `reg_dst`, `jump`, `jr`, `branch`, `bne`, `mem2reg`, `alu_src`, `and_data2alu`, `shift_ren`, `shift_len`, `shift_data2reg` out 1 each: datapath controls decoded from `ir`.
- `alu_ctrl` out 4: ALU operation.
- `reg_wrt` out 1: register-file write strobe.
- `pc_en` out 1: PC load enable (one pulse per instruction).
- `dmem_rd`, `dmem_wr` out 1 each: data-memory request, held until ack or timeout.
- `illegal_op` out 1: one-cycle pulse when an undecodable instruction is skipped.
- `bus_err` out 1: one-cycle pulse on memory timeout.
- `retired` out 32: count of successfully retired instructions.

## Operation
- **States:** FETCH, EXEC, MEM.
- **FETCH**
  - All strobes are low.
  - On `inst_valid`, `ir <= inst` and the FSM moves to EXEC. Otherwise it stays in FETCH.
- **Decode** is combinational from `ir` and valid in every state. Rows below give opcode [31:26] / funct [5:0]; any control not listed is 0.
  - R-type (opcode 0x00), all with `reg_dst`:
    - add 0x20: `alu_ctrl`=0010.
    - sub 0x22: 0110.
    - and 0x24: 0000.
    - or 0x25: 0001.
    - slt 0x2A: 0111.
    - sll 0x00: `shift_len`, `shift_data2reg`.
    - srl 0x02: `shift_ren`, `shift_data2reg`.
    - jr 0x08: `jr` (no `reg_dst`, no write).
  - I/J-type:
    - addi 0x08: `alu_src`, 0010.
    - andi 0x0C: `and_data2alu`, 0000.
    - lw 0x23: `alu_src`, `mem2reg`, 0010.
    - sw 0x2B: `alu_src`, 0010.
    - beq 0x04: `branch`, 0110.
    - bne 0x05: `bne`, 0110.
    - j 0x02: `jump`.
  - Anything else is illegal, and all its controls are 0.
- **EXEC** (exactly one cycle)
  - Legal non-memory instruction: `pc_en`=1. `reg_wrt`=1 for the ALU, shift and immediate ops, and 0 for beq/bne/j/jr. `retired` increments. Next state is FETCH.
  - lw/sw: `pc_en`=0, `reg_wrt`=0. Next state is MEM with the wait counter cleared.
  - Illegal: `pc_en`=1, `reg_wrt`=0, `illegal_op`=1, `retired` unchanged. Next state is FETCH.
- **MEM**
  - `dmem_rd` (lw) or `dmem_wr` (sw) stays high every cycle in MEM.
  - Decoded controls stay stable, so the address/store data are held.
  - On `dmem_ack`: `pc_en`=1, `reg_wrt`=1 for lw only, `retired` increments, and the FSM returns to FETCH.
  - If there is no ack and the wait counter equals TIMEOUT-1: `bus_err`=1, `pc_en`=1, no write, `retired` unchanged, and the FSM returns to FETCH.
  - Otherwise the counter increments.
- `retired` wraps from 0xFFFFFFFF to 0.

## Timing
- **Reset value** (in effect the cycle after `reset` is sampled high):
  - state FETCH, `ir`=0 (decodes as sll $0 = nop), wait counter 0, `retired`=0.
  - All strobes (`reg_wrt`, `pc_en`, `dmem_rd`, `dmem_wr`, `illegal_op`, `bus_err`) are 0.
  - The decoded controls follow `ir`=0: `reg_dst`, `shift_len` and `shift_data2reg` read 1 and all other controls 0. This is harmless because every strobe is low.
- Reset takes priority over every input, including a `dmem_ack` in the same cycle. Reset during MEM drops the request immediately; no write and no `pc_en`.
- **Latency:**
  - Non-memory instructions take 2 cycles from the `inst_valid` edge to the `pc_en` pulse (FETCH→EXEC).
  - lw/sw take 2+N cycles, where N≥1 is the number of MEM cycles up to and including the ack.
  - Timeout takes 2+TIMEOUT cycles.
- `dmem_ack` is sampled only in MEM; acks in FETCH/EXEC are ignored. An ack in the same cycle as the timeout condition wins, so the access completes normally with no `bus_err`.
- `inst_valid` is ignored outside FETCH.
- `pc_en`, `illegal_op` and `bus_err` are single-cycle pulses. `pc_en` fires exactly once per instruction.
- `reg_wrt` is only high in a cycle where `pc_en` is also high.
- `ir` changes only on the FETCH→EXEC edge.

## Test plan
- **add:** reset, then `inst`=0x01095020 (add $10,$8,$9) with `inst_valid`=1 for one cycle → next cycle EXEC: `reg_dst`=1, `alu_ctrl`=0010, `reg_wrt`=1, `pc_en`=1; `retired`=1 afterwards.
- **lw with wait states:** `inst`=0x8D280004 (lw $8,4($9)), ack 3 cycles into MEM → `dmem_rd` high for 3 cycles. On the ack cycle `mem2reg`=1, `reg_wrt`=1, `pc_en`=1; `dmem_rd` is low the next cycle.
- **sw timeout:** `inst`=0xAD280000, TIMEOUT=16, no ack → `dmem_wr` high 16 cycles, `bus_err` and `pc_en` pulse on the 16th, `reg_wrt` never high, `retired` unchanged. Repeat with ack on cycle 16 → no `bus_err`, `retired` increments.
- **beq then j:** `inst`=0x11090003 (beq) → `branch`=1, `alu_ctrl`=0110, `pc_en`=1, `reg_wrt`=0. Then 0x08000010 (j) → `jump`=1, `reg_wrt`=0.
- **Illegal opcode:** `inst`=0xFC000000 → `illegal_op` and `pc_en` pulse together in EXEC, all controls 0, `retired` unchanged. Also drive `inst_valid` during EXEC → ignored.
- **Reset mid-access:** assert `reset` on the 2nd MEM cycle of an lw while `dmem_ack`=1 → no `reg_wrt`/`pc_en`; next cycle state FETCH, `dmem_rd`=0, `ir`=0, `retired`=0.
